csr_access_ctrl: RTL and testbench

- Sequencer and arbiter for the single-read/single-write CSR register file.
- Serves two requesters:
  - CSR instructions (CSRRW/CSRRS/CSRRC) from the EX stage, executed as a two-cycle atomic read-modify-write.
  - The trap unit, which needs three CSR writes (mepc, mcause, mtval) followed by a read of mtvec to produce the redirect PC.
- Sits between the EX/trap logic and the CSR file; owns the file's read address, write enable, write address and write data.

---
 rtl/csr_access_ctrl_if.sv | 56 +++++
 rtl/csr_access_ctrl.sv | 159 +++++++++++++++
 tb/tb_csr_access_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_access_ctrl_if.sv
// Requester/CSR-file bundle for csr_access_ctrl.
// Latency: none, wiring only.
// Backpressure: requests are levels held until the matching done pulse; ex_stall tells the front end to wait.
// Ports (signals): ex_* CSR instruction request/response, trap_* trap request/response,
// csr_* read/write port of the CSR register file.
// ex_illegal exists only when CSR_RO_CHECK_EN is defined.
interface csr_access_ctrl_if;
    logic        ex_req;
    logic [1:0]  ex_op;
    logic [11:0] ex_addr;
    logic [31:0] ex_wdata;
    logic        ex_wr_nz;
    logic        ex_done;
    logic [31:0] ex_rdata;
    logic        ex_stall;
`ifdef CSR_RO_CHECK_EN
    logic        ex_illegal;
`endif
    logic        trap_req;
    logic [31:0] trap_pc;
    logic [31:0] trap_cause;
    logic [31:0] trap_tval;
    logic        trap_done;
    logic [31:0] redirect_pc;
    logic [11:0] csr_ra;
    logic [31:0] csr_rd;
    logic        csr_we;
    logic [11:0] csr_wa;
    logic [31:0] csr_wd;

    // Environment side: EX stage, trap unit and the CSR file.
    modport master (
        output ex_req, ex_op, ex_addr, ex_wdata, ex_wr_nz,
        input  ex_done, ex_rdata, ex_stall,
`ifdef CSR_RO_CHECK_EN
        input  ex_illegal,
`endif
        output trap_req, trap_pc, trap_cause, trap_tval,
        input  trap_done, redirect_pc,
        input  csr_ra, csr_we, csr_wa, csr_wd,
        output csr_rd
    );

    // Controller side.
    modport slave (
        input  ex_req, ex_op, ex_addr, ex_wdata, ex_wr_nz,
        output ex_done, ex_rdata, ex_stall,
`ifdef CSR_RO_CHECK_EN
        output ex_illegal,
`endif
        input  trap_req, trap_pc, trap_cause, trap_tval,
        output trap_done, redirect_pc,
        output csr_ra, csr_we, csr_wa, csr_wd,
        input  csr_rd
    );
endinterface

// File: rtl/csr_access_ctrl.sv
// Sequencer/arbiter owning the CSR file port: atomic RMW for CSR instructions, 3 writes + mtvec read for traps.
// Latency: CSR instruction 2 cycles (ex_done in 2nd), trap 4 cycles (trap_done in 4th); >=1 idle cycle between.
// Backpressure: requests are held levels; ex_stall=1 whenever busy or a request is pending; trap wins ties only in IDLE.
// Ports: clk, rst (synchronous, active high); bus (csr_access_ctrl_if.slave) carries
// ex_* / trap_* requester handshakes and the csr_* register-file port.
// Optional build macro CSR_RO_CHECK_EN: suppresses writes to addr[11:10]==2'b11 and adds ex_illegal.
module csr_access_ctrl #(
    parameter logic [11:0] ADDR_MEPC   = 12'h341,
    parameter logic [11:0] ADDR_MCAUSE = 12'h342,
    parameter logic [11:0] ADDR_MTVAL  = 12'h343,
    parameter logic [11:0] ADDR_MTVEC  = 12'h305
) (
    input  logic            clk,
    input  logic            rst,
    csr_access_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, C_RD, C_WR, T_EPC, T_CAUSE, T_TVAL, T_VEC
    } state_t;

    state_t      state;

    // CSR instruction fields captured at acceptance so a requester that
    // drops early still gets a consistent RMW.
    logic [1:0]  op_q;
    logic [11:0] addr_q;
    logic [31:0] wdata_q;
    logic        wr_nz_q;
    logic [31:0] old_q;

    // Registered file-port and pulse outputs; each value is computed on the
    // edge that enters the state it belongs to.
    logic [11:0] csr_ra_q;
    logic        csr_we_q;
    logic [11:0] csr_wa_q;
    logic [31:0] csr_wd_q;
    logic        ex_done_q;
    logic        trap_done_q;

    logic [31:0] rmw_val;
    logic        wants_write;
    logic        ro_hit;

    // New value from the combinational read data seen during C_RD.
    always_comb begin
        rmw_val = bus.csr_rd;
        case (op_q)
            2'b01:   rmw_val = wdata_q;
            2'b10:   rmw_val = bus.csr_rd | wdata_q;
            2'b11:   rmw_val = bus.csr_rd & ~wdata_q;
            default: rmw_val = bus.csr_rd;
        endcase
    end

    // RS/RC with a zero source operand must not write (no side effects).
    assign wants_write = (op_q == 2'b01) || ((op_q != 2'b00) && wr_nz_q);

`ifdef CSR_RO_CHECK_EN
    logic illegal_q;
    assign ro_hit = (addr_q[11:10] == 2'b11);
`else
    assign ro_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op_q        <= 2'b00;
            addr_q      <= 12'h0;
            wdata_q     <= 32'h0;
            wr_nz_q     <= 1'b0;
            old_q       <= 32'h0;
            csr_ra_q    <= 12'h0;
            csr_we_q    <= 1'b0;
            csr_wa_q    <= 12'h0;
            csr_wd_q    <= 32'h0;
            ex_done_q   <= 1'b0;
            trap_done_q <= 1'b0;
`ifdef CSR_RO_CHECK_EN
            illegal_q   <= 1'b0;
`endif
        end else begin
            // Idle-valued outputs unless the next state drives them.
            csr_ra_q    <= 12'h0;
            csr_we_q    <= 1'b0;
            csr_wa_q    <= 12'h0;
            csr_wd_q    <= 32'h0;
            ex_done_q   <= 1'b0;
            trap_done_q <= 1'b0;
`ifdef CSR_RO_CHECK_EN
            illegal_q   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.trap_req) begin
                        state    <= T_EPC;
                        csr_we_q <= 1'b1;
                        csr_wa_q <= ADDR_MEPC;
                        csr_wd_q <= bus.trap_pc & 32'hFFFF_FFFE;
                    end else if (bus.ex_req) begin
                        state    <= C_RD;
                        op_q     <= bus.ex_op;
                        addr_q   <= bus.ex_addr;
                        wdata_q  <= bus.ex_wdata;
                        wr_nz_q  <= bus.ex_wr_nz;
                        csr_ra_q <= bus.ex_addr;
                    end
                end
                C_RD: begin
                    state     <= C_WR;
                    old_q     <= bus.csr_rd;
                    csr_we_q  <= wants_write & ~ro_hit;
                    csr_wa_q  <= addr_q;
                    csr_wd_q  <= rmw_val;
                    ex_done_q <= 1'b1;
`ifdef CSR_RO_CHECK_EN
                    illegal_q <= wants_write & ro_hit;
`endif
                end
                C_WR: state <= IDLE;
                T_EPC: begin
                    state    <= T_CAUSE;
                    csr_we_q <= 1'b1;
                    csr_wa_q <= ADDR_MCAUSE;
                    csr_wd_q <= bus.trap_cause;
                end
                T_CAUSE: begin
                    state    <= T_TVAL;
                    csr_we_q <= 1'b1;
                    csr_wa_q <= ADDR_MTVAL;
                    csr_wd_q <= bus.trap_tval;
                end
                T_TVAL: begin
                    state       <= T_VEC;
                    csr_ra_q    <= ADDR_MTVEC;
                    trap_done_q <= 1'b1;
                end
                T_VEC:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The file commits mid-cycle, so a reset raised during a write state must
    // also block that cycle's write and pulses, not only the following ones.
    assign bus.csr_ra      = csr_ra_q;
    assign bus.csr_we      = csr_we_q & ~rst;
    assign bus.csr_wa      = csr_wa_q;
    assign bus.csr_wd      = csr_wd_q;
    assign bus.ex_done     = ex_done_q & ~rst;
    assign bus.ex_rdata    = ex_done_q ? old_q : 32'h0;
    assign bus.trap_done   = trap_done_q & ~rst;
    // mtvec is read combinationally in T_VEC; mode bits are masked off.
    assign bus.redirect_pc = trap_done_q ? (bus.csr_rd & 32'hFFFF_FFFC) : 32'h0;
    assign bus.ex_stall    = ~rst & ((state != IDLE) | bus.ex_req | bus.trap_req);
`ifdef CSR_RO_CHECK_EN
    assign bus.ex_illegal  = illegal_q & ~rst;
`endif
endmodule

// File: tb/tb_csr_access_ctrl.sv
// Self-checking bench for csr_access_ctrl with a behavioural CSR file and reference model.
// Latency: checks 2-cycle RMW and 4-cycle trap sequences.
// Backpressure: requests held as levels until their done pulse, then dropped.
module tb_csr_access_ctrl;
    logic clk;
    logic rst;
    csr_access_ctrl_if bus ();

    csr_access_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef CSR_RO_CHECK_EN
    localparam bit RO_BUILD = 1'b1;
`else
    localparam bit RO_BUILD = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural CSR file: combinational read, write committed mid-cycle.
    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;

    logic [31:0] mem [4096];
    wr_t         wlog [$];
    logic        pre_we;
    logic [11:0] pre_a;
    logic [31:0] pre_d;

    assign bus.csr_rd = mem[bus.csr_ra];

    always @(negedge clk) begin
        if (pre_we) begin
            mem[pre_a] <= pre_d;
        end else if (bus.csr_we) begin
            mem[bus.csr_wa] <= bus.csr_wd;
            wlog.push_back('{a: bus.csr_wa, d: bus.csr_wd});
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at posedge+1 while the controller is idle; returns at posedge+1.
    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        pre_a  = a;
        pre_d  = d;
        pre_we = 1'b1;
        @(negedge clk);
        #1 pre_we = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Raises ex_req at cycle ex_at and trap_req at cycle tr_at (-1 = never),
    // drops each after its done pulse. Latencies are relative to the raise cycle.
    task automatic run_both(input int ex_at, input int tr_at,
                            input logic [1:0] op, input logic [11:0] addr,
                            input logic [31:0] wd, input logic nz,
                            input logic [31:0] pc, input logic [31:0] cause,
                            input logic [31:0] tval,
                            output int elat, output int tlat,
                            output logic [31:0] erd, output logic [31:0] redir,
                            output logic eill);
        elat = -1; tlat = -1; erd = 32'h0; redir = 32'h0; eill = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (k == ex_at) begin
                bus.ex_op = op; bus.ex_addr = addr; bus.ex_wdata = wd;
                bus.ex_wr_nz = nz; bus.ex_req = 1'b1;
            end
            if (k == tr_at) begin
                bus.trap_pc = pc; bus.trap_cause = cause; bus.trap_tval = tval;
                bus.trap_req = 1'b1;
            end
            @(negedge clk);
            if (bus.ex_done) begin
                elat = k - ex_at;
                erd  = bus.ex_rdata;
`ifdef CSR_RO_CHECK_EN
                eill = bus.ex_illegal;
`endif
            end
            if (bus.trap_done) begin
                tlat  = k - tr_at;
                redir = bus.redirect_pc;
            end
            @(posedge clk);
            #1;
            if (elat >= 0) bus.ex_req = 1'b0;
            if (tlat >= 0) bus.trap_req = 1'b0;
            if ((ex_at < 0 || elat >= 0) && (tr_at < 0 || tlat >= 0)) break;
        end
        bus.ex_req   = 1'b0;
        bus.trap_req = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] init;
        logic [31:0] wd;
        logic        nz;
        logic [31:0] exp_new;
        logic        exp_we;
        logic        exp_ill;
    } vec_t;

    vec_t vecs [10];

    logic [11:0] aset [8] = '{12'h340, 12'h341, 12'h342, 12'h343,
                              12'h305, 12'h300, 12'hC00, 12'hF11};
    logic [31:0] ref_mem [logic [11:0]];

    initial begin
        int          elat, tlat, n0;
        logic [31:0] erd, redir, exp_redir, oldv, newv, pc, cause, tval, wd;
        logic        eill, nz, wr, td_seen;
        logic [1:0]  op;
        logic [11:0] a;

        rst = 1'b1; pre_we = 1'b0; pre_a = 12'h0; pre_d = 32'h0;
        bus.ex_req = 1'b0; bus.ex_op = 2'b00; bus.ex_addr = 12'h0;
        bus.ex_wdata = 32'h0; bus.ex_wr_nz = 1'b0;
        bus.trap_req = 1'b0; bus.trap_pc = 32'h0; bus.trap_cause = 32'h0;
        bus.trap_tval = 32'h0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_csr_ra", 32'(bus.csr_ra), 32'h0);
        chk("rst_csr_we", 32'(bus.csr_we), 32'h0);
        chk("rst_csr_wa", 32'(bus.csr_wa), 32'h0);
        chk("rst_csr_wd", bus.csr_wd, 32'h0);
        chk("rst_ex_done", 32'(bus.ex_done), 32'h0);
        chk("rst_ex_rdata", bus.ex_rdata, 32'h0);
        chk("rst_trap_done", 32'(bus.trap_done), 32'h0);
        chk("rst_redirect", bus.redirect_pc, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_stall", 32'(bus.ex_stall), 32'h0);
        chk("idle_we", 32'(bus.csr_we), 32'h0);
        @(posedge clk);
        #1;

        // ---- table-driven CSR instructions ----
        vecs[0] = '{2'b01, 12'h340, 32'h0000_00AA, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 1'b0};
        vecs[1] = '{2'b10, 12'h340, 32'h0F0F_0000, 32'h0000_00FF, 1'b1, 32'h0F0F_00FF, 1'b1, 1'b0};
        vecs[2] = '{2'b10, 12'h340, 32'h0F0F_0000, 32'h0000_00FF, 1'b0, 32'h0F0F_0000, 1'b0, 1'b0};
        vecs[3] = '{2'b11, 12'h340, 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b1, 32'hFFFF_0000, 1'b1, 1'b0};
        vecs[4] = '{2'b11, 12'h341, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 32'h1234_5678, 1'b0, 1'b0};
        vecs[5] = '{2'b00, 12'h300, 32'hCAFE_F00D, 32'h0000_5555, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0};
        vecs[6] = '{2'b01, 12'h305, 32'h0000_0000, 32'h8000_0103, 1'b0, 32'h8000_0103, 1'b1, 1'b0};
        vecs[7] = '{2'b01, 12'hC00, 32'h1111_1111, 32'h2222_2222, 1'b1,
                    RO_BUILD ? 32'h1111_1111 : 32'h2222_2222, !RO_BUILD, RO_BUILD};
        vecs[8] = '{2'b10, 12'hC01, 32'h0000_00F0, 32'h0000_0F00, 1'b1,
                    RO_BUILD ? 32'h0000_00F0 : 32'h0000_0FF0, !RO_BUILD, RO_BUILD};
        vecs[9] = '{2'b10, 12'hC02, 32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0001, 1'b0, 1'b0};

        for (int i = 0; i < 10; i++) begin
            preload(vecs[i].addr, vecs[i].init);
            n0 = wlog.size();
            run_both(0, -1, vecs[i].op, vecs[i].addr, vecs[i].wd, vecs[i].nz,
                     32'h0, 32'h0, 32'h0, elat, tlat, erd, redir, eill);
            chk($sformatf("vec%0d_latency", i), 32'(elat), 32'd2);
            chk($sformatf("vec%0d_rdata", i), erd, vecs[i].init);
            chk($sformatf("vec%0d_newval", i), mem[vecs[i].addr], vecs[i].exp_new);
            chk($sformatf("vec%0d_we_seen", i), 32'(wlog.size() > n0), 32'(vecs[i].exp_we));
            chk($sformatf("vec%0d_illegal", i), 32'(eill), 32'(vecs[i].exp_ill));
            @(negedge clk);
            chk($sformatf("vec%0d_idle_after", i), 32'(bus.ex_stall), 32'h0);
            @(posedge clk);
            #1;
        end

        // ---- trap sequence ----
        preload(12'h305, 32'h8000_0103);
        n0 = wlog.size();
        run_both(-1, 0, 2'b00, 12'h0, 32'h0, 1'b0, 32'h8000_0011, 32'h2, 32'hDEAD_BEEF,
                 elat, tlat, erd, redir, eill);
        chk("trap_latency", 32'(tlat), 32'd4);
        chk("trap_redirect", redir, 32'h8000_0100);
        chk("trap_nwrites", 32'(wlog.size() - n0), 32'd3);
        if (wlog.size() >= n0 + 3) begin
            chk("trap_w0_addr", 32'(wlog[n0].a), 32'h341);
            chk("trap_w0_data", wlog[n0].d, 32'h8000_0010);
            chk("trap_w1_addr", 32'(wlog[n0+1].a), 32'h342);
            chk("trap_w1_data", wlog[n0+1].d, 32'h0000_0002);
            chk("trap_w2_addr", 32'(wlog[n0+2].a), 32'h343);
            chk("trap_w2_data", wlog[n0+2].d, 32'hDEAD_BEEF);
        end

        // ---- simultaneous requests: trap first, RMW reads the new mcause ----
        run_both(0, 0, 2'b10, 12'h342, 32'h0000_0100, 1'b1, 32'h0000_2000, 32'h0000_000B,
                 32'h0, elat, tlat, erd, redir, eill);
        chk("tie_trap_latency", 32'(tlat), 32'd4);
        chk("tie_ex_latency", 32'(elat), 32'd7);
        chk("tie_ex_rdata", erd, 32'h0000_000B);
        chk("tie_mcause", mem[12'h342], 32'h0000_010B);

        // ---- trap raised during C_RD waits for ex_done ----
        n0 = wlog.size();
        run_both(0, 1, 2'b01, 12'h341, 32'h0000_7777, 1'b1, 32'h0000_4444, 32'h1, 32'h2,
                 elat, tlat, erd, redir, eill);
        chk("crd_ex_latency", 32'(elat), 32'd2);
        chk("crd_trap_latency", 32'(tlat), 32'd6);
        chk("crd_nwrites", 32'(wlog.size() - n0), 32'd4);
        if (wlog.size() >= n0 + 2) begin
            chk("crd_first_write", wlog[n0].d, 32'h0000_7777);
            chk("crd_second_write", wlog[n0+1].d, 32'h0000_4444);
        end

        // ---- reset in T_CAUSE ----
        preload(12'h341, 32'h0);
        preload(12'h342, 32'h5A5A_5A5A);
        preload(12'h343, 32'hA5A5_A5A5);
        n0 = wlog.size();
        td_seen = 1'b0;
        bus.trap_pc = 32'h0000_0100; bus.trap_cause = 32'h7; bus.trap_tval = 32'h9;
        bus.trap_req = 1'b1;
        @(posedge clk); #1;               // T_EPC
        @(posedge clk); #1;               // T_CAUSE
        rst = 1'b1;
        bus.trap_req = 1'b0;
        @(negedge clk);
        chk("rstmid_we_blocked", 32'(bus.csr_we), 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rstmid_idle", 32'(bus.ex_stall), 32'h0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.trap_done) td_seen = 1'b1;
        end
        @(posedge clk); #1;
        chk("rstmid_no_done", 32'(td_seen), 32'h0);
        chk("rstmid_nwrites", 32'(wlog.size() - n0), 32'd1);
        chk("rstmid_mepc", mem[12'h341], 32'h0000_0100);
        chk("rstmid_mcause", mem[12'h342], 32'h5A5A_5A5A);
        chk("rstmid_mtval", mem[12'h343], 32'hA5A5_A5A5);

        // ---- randomized traffic against the reference model ----
        foreach (aset[j]) begin
            ref_mem[aset[j]] = $urandom;
            preload(aset[j], ref_mem[aset[j]]);
        end
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                pc = $urandom; cause = $urandom; tval = $urandom;
                exp_redir = ref_mem[12'h305] & 32'hFFFF_FFFC;
                run_both(-1, 0, 2'b00, 12'h0, 32'h0, 1'b0, pc, cause, tval,
                         elat, tlat, erd, redir, eill);
                chk("rnd_trap_latency", 32'(tlat), 32'd4);
                chk("rnd_redirect", redir, exp_redir);
                ref_mem[12'h341] = {pc[31:1], 1'b0};
                ref_mem[12'h342] = cause;
                ref_mem[12'h343] = tval;
            end else begin
                op = 2'($urandom_range(0, 3));
                a  = aset[$urandom_range(0, 7)];
                wd = $urandom;
                nz = 1'($urandom_range(0, 1));
                oldv = ref_mem[a];
                case (op)
                    2'b01:   newv = wd;
                    2'b10:   newv = oldv | wd;
                    2'b11:   newv = oldv & ~wd;
                    default: newv = oldv;
                endcase
                wr = (op == 2'b01) || (op != 2'b00 && nz);
                if (RO_BUILD && a[11:10] == 2'b11) wr = 1'b0;
                run_both(0, -1, op, a, wd, nz, 32'h0, 32'h0, 32'h0,
                         elat, tlat, erd, redir, eill);
                chk("rnd_ex_latency", 32'(elat), 32'd2);
                chk("rnd_ex_rdata", erd, oldv);
                if (wr) ref_mem[a] = newv;
                chk("rnd_mem", mem[a], ref_mem[a]);
            end
        end
        foreach (aset[j]) chk($sformatf("final_%h", aset[j]), mem[aset[j]], ref_mem[aset[j]]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
